// File: rtl/nibble_sequencer.sv
// -----------------------------------------------------------------------------
// nibble_sequencer
// Program counter and instruction sequencer for the Nibbler CPU. Fetches
// instruction bytes from a combinational program ROM, sequences single-byte
// ALU/NOP instructions (FETCH -> EXEC) and two-byte jumps (FETCH -> ADDR),
// resolves conditional jumps from the Flags register and generates the
// Flags register load strobe.
//
// Ports:
//   clk        in   system clock, rising edge active
//   reset      in   asynchronous active-low reset
//   instr      in   ROM data at address pc_out (combinational)
//   flags      in   {C, Z} from the Flags register
//   hold       in   freeze state/pc/ir and suppress strobes
//   pc_out     out  program counter (ROM address)
//   ir_out     out  instruction register {opcode, operand}
//   phase      out  0 FETCH, 1 EXEC, 2 ADDR
//   flags_load out  Flags register capture strobe (EXEC of an ALU op)
//   jump_taken out  high in the ADDR cycle that loads the jump target
// -----------------------------------------------------------------------------
module nibble_sequencer #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        instr,
  input  logic [1:0]        flags,
  input  logic              hold,
  output logic [ADDR_W-1:0] pc_out,
  output logic [7:0]        ir_out,
  output logic [1:0]        phase,
  output logic              flags_load,
  output logic              jump_taken
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_ADDR  = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_ir;

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_target;
  logic              w_fetch_is_jump;
  logic              w_cond;

  // Natural ADDR_W-bit overflow gives the required 0xFFF -> 0x000 wrap.
  assign w_pc_inc = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign w_target = {r_ir[3:0], instr};

  // Opcodes 0x8..0xC are two-byte jumps; everything else executes in EXEC.
  assign w_fetch_is_jump = (instr[7:4] >= 4'h8) && (instr[7:4] <= 4'hC);

  // Jump condition decode from the latched opcode; flags = {C, Z}.
  always_comb begin
    w_cond = 1'b0;
    case (r_ir[7:4])
      4'h8:    w_cond = flags[1];
      4'h9:    w_cond = ~flags[1];
      4'hA:    w_cond = flags[0];
      4'hB:    w_cond = ~flags[0];
      4'hC:    w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  // Strobes are pure decodes of the current state; reset forces the state to
  // FETCH asynchronously, so both drop the instant reset asserts.
  assign flags_load = ~hold && (r_state == S_EXEC) && ~r_ir[7];
  assign jump_taken = ~hold && (r_state == S_ADDR) && w_cond;

  // Sequencer state machine with PC and instruction register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_pc    <= {ADDR_W{1'b0}};
      r_ir    <= 8'h00;
    end else if (hold) begin
      r_state <= r_state;
      r_pc    <= r_pc;
      r_ir    <= r_ir;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_ir    <= instr;
          r_pc    <= w_pc_inc;
          r_state <= w_fetch_is_jump ? S_ADDR : S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_FETCH;
        end
        S_ADDR: begin
          // Not taken still advances past the address byte.
          r_pc    <= w_cond ? w_target : w_pc_inc;
          r_state <= S_FETCH;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  assign pc_out = r_pc;
  assign ir_out = r_ir;
  assign phase  = r_state;

endmodule

// File: tb/tb_nibble_sequencer.sv
module tb_nibble_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  instr;
  logic [1:0]  flags;
  logic        hold;
  logic [11:0] pc_out;
  logic [7:0]  ir_out;
  logic [1:0]  phase;
  logic        flags_load;
  logic        jump_taken;

  logic [7:0]  rom [4096];
  int          errors;
  int          checks;
  logic [11:0] mpc;

  nibble_sequencer #(.ADDR_W(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .flags      (flags),
    .hold       (hold),
    .pc_out     (pc_out),
    .ir_out     (ir_out),
    .phase      (phase),
    .flags_load (flags_load),
    .jump_taken (jump_taken)
  );

  assign instr = rom[pc_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural jump rule: C = f[1], Z = f[0].
  function automatic bit jump_rule(input logic [3:0] opc, input logic [1:0] f);
    if (opc == 4'h8) return f[1] == 1'b1;
    if (opc == 4'h9) return f[1] == 1'b0;
    if (opc == 4'hA) return f[0] == 1'b1;
    if (opc == 4'hB) return f[0] == 1'b0;
    return 1'b1;
  endfunction

  // Execute one whole instruction starting at a negedge in FETCH; returns at
  // the negedge of the following FETCH with pc updated to the next instruction.
  task automatic run_instr(input logic [1:0] f, inout logic [11:0] pc);
    logic [7:0]  op;
    logic [11:0] a1;
    logic [11:0] a2;
    bit          tk;
    op = rom[pc];
    a1 = pc + 12'd1;
    a2 = pc + 12'd2;
    flags = f;
    #1;
    chk("fetch_phase", 16'(phase), 16'd0);
    chk("fetch_pc", 16'(pc_out), 16'(pc));
    chk("fetch_fl", 16'(flags_load), 16'd0);
    chk("fetch_jt", 16'(jump_taken), 16'd0);
    @(negedge clk); #1;
    chk("ir", 16'(ir_out), 16'(op));
    chk("pc_inc", 16'(pc_out), 16'(a1));
    if (op[7:4] >= 4'h8 && op[7:4] <= 4'hC) begin
      tk = jump_rule(op[7:4], f);
      chk("addr_phase", 16'(phase), 16'd2);
      chk("addr_fl", 16'(flags_load), 16'd0);
      chk("addr_jt", 16'(jump_taken), 16'(tk));
      pc = tk ? {op[3:0], rom[a1]} : a2;
    end else begin
      chk("exec_phase", 16'(phase), 16'd1);
      chk("exec_fl", 16'(flags_load), 16'(op[7:4] < 4'h8));
      chk("exec_jt", 16'(jump_taken), 16'd0);
      pc = a1;
    end
    @(negedge clk);
  endtask

  // Pulse reset for one cycle from a negedge; next edge is the first fetch.
  task automatic do_reset(output logic [11:0] pc);
    reset = 1'b0;
    #1;
    chk("rst_pc", 16'(pc_out), 16'h000);
    chk("rst_phase", 16'(phase), 16'd0);
    chk("rst_jt", 16'(jump_taken), 16'd0);
    @(negedge clk);
    reset = 1'b1;
    pc = 12'h000;
  endtask

  logic [3:0]  jops  [8] = '{4'hA, 4'hA, 4'h8, 4'h8, 4'h9, 4'h9, 4'hB, 4'hB};
  logic [1:0]  jflg  [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01};
  logic [11:0] jdest [8] = '{12'h567, 12'h002, 12'h567, 12'h002,
                             12'h567, 12'h002, 12'h567, 12'h002};

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    hold   = 1'b0;
    flags  = 2'b00;
    for (int i = 0; i < 4096; i++) rom[i] = 8'hD0;

    // Reset held for 3 cycles.
    rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'hD0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_pc", 16'(pc_out), 16'h000);
      chk("rst_phase", 16'(phase), 16'd0);
      chk("rst_ir", 16'(ir_out), 16'h00);
      chk("rst_fl", 16'(flags_load), 16'd0);
      chk("rst_jt", 16'(jump_taken), 16'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    mpc = 12'h000;

    // Straight-line ALU ops then NOP.
    repeat (3) run_instr(2'b00, mpc);
    chk("line_end_pc", 16'(pc_out), 16'h003);

    // Conditional jumps, taken and not taken.
    for (int k = 0; k < 8; k++) begin
      do_reset(mpc);
      rom[0] = {jops[k], 4'h5};
      rom[1] = 8'h67;
      run_instr(jflg[k], mpc);
      chk("jump_dest", 16'(pc_out), 16'(jdest[k]));
    end

    // NOP at 0xFFF wraps to 0x000.
    do_reset(mpc);
    rom[0] = 8'hCF; rom[1] = 8'hFF; rom[12'hFFF] = 8'hD0;
    run_instr(2'b00, mpc);
    chk("wrap_jump_pc", 16'(pc_out), 16'hFFF);
    run_instr(2'b00, mpc);
    chk("wrap_nop_pc", 16'(pc_out), 16'h000);

    // Not-taken JNZ at 0xFFE wraps to 0x000.
    do_reset(mpc);
    rom[0] = 8'hCF; rom[1] = 8'hFE; rom[12'hFFE] = 8'hB1; rom[12'hFFF] = 8'h23;
    run_instr(2'b00, mpc);
    run_instr(2'b01, mpc);
    chk("wrap_jnz_pc", 16'(pc_out), 16'h000);

    // Hold during EXEC for 4 cycles.
    do_reset(mpc);
    rom[0] = 8'h12;
    @(negedge clk);
    hold = 1'b1;
    #1;
    chk("hold_fl", 16'(flags_load), 16'd0);
    repeat (4) begin
      @(negedge clk); #1;
      chk("hold_pc", 16'(pc_out), 16'h001);
      chk("hold_ir", 16'(ir_out), 16'h12);
      chk("hold_phase", 16'(phase), 16'd1);
      chk("hold_fl", 16'(flags_load), 16'd0);
    end
    hold = 1'b0;
    #1;
    chk("unhold_fl", 16'(flags_load), 16'd1);
    @(negedge clk); #1;
    chk("unhold_phase", 16'(phase), 16'd0);
    chk("unhold_fl_once", 16'(flags_load), 16'd0);
    chk("unhold_pc", 16'(pc_out), 16'h001);

    // Reset during a taken jump's ADDR cycle.
    @(negedge clk);
    do_reset(mpc);
    rom[0] = 8'hA5; rom[1] = 8'h67;
    flags = 2'b01;
    @(negedge clk); #1;
    chk("midjump_jt_before", 16'(jump_taken), 16'd1);
    reset = 1'b0;
    #1;
    chk("midjump_jt", 16'(jump_taken), 16'd0);
    chk("midjump_pc", 16'(pc_out), 16'h000);
    chk("midjump_phase", 16'(phase), 16'd0);
    @(negedge clk); #1;
    chk("midjump_pc_held", 16'(pc_out), 16'h000);
    @(negedge clk);
    reset = 1'b1;
    mpc = 12'h000;
    run_instr(2'b00, mpc);
    chk("midjump_restart_pc", 16'(pc_out), 16'h002);

    // Randomised program against the instruction-level model.
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    do_reset(mpc);
    for (int n = 0; n < 400; n++) run_instr(2'($urandom), mpc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_sequencer.md
# nibble_sequencer

Program-counter and instruction sequencer for the Nibbler CPU. It fetches instruction bytes from program ROM and sequences single-byte ALU instructions and two-byte jumps. It consumes the 2-bit output of the Flags register to resolve conditional jumps, and it generates the load strobe that tells the Flags register when to capture new ALU carry/zero results.

## Interface
- ADDR_W, 12: program counter width; jump target is {operand nibble, second byte}, so ADDR_W = 12 is the only supported value.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- instr  in  8  ROM data at address pc_out; valid combinationally in the same cycle.
- flags  in  2  registered flags from the Flags register; flags[1] = C, flags[0] = Z.
- hold  in  1  when 1, freezes state, pc_out and ir_out; all strobes are forced to 0.
- pc_out  out  12  current program counter, driving the ROM address.
- ir_out  out  8  latched instruction register; opcode = ir_out[7:4], operand = ir_out[3:0].
- phase  out  2  current state encoding: 0 FETCH, 1 EXEC, 2 ADDR.
- flags_load  out  1  strobe to the Flags register enable.
- jump_taken  out  1  high during the ADDR cycle in which the PC is loaded with the jump target.

## Operation
- Opcode classes are selected by ir_out[7:4]:
  - 0x0–0x7: ALU ops; these update the flags.
  - 0x8 JC, 0x9 JNC, 0xA JZ, 0xB JNZ, 0xC J (unconditional).
  - 0xD–0xF: NOP class; no flag update.
- State machine, three states:
  - FETCH: ir_out <= instr; pc_out <= pc_out + 1. Next state is ADDR if instr[7:4] is in 0x8–0xC, otherwise EXEC.
  - EXEC: flags_load = 1 if ir_out[7] = 0, else 0. No PC change. Next state is FETCH.
  - ADDR: target = {ir_out[3:0], instr}.
    - Conditions: JC taken if C = 1; JNC if C = 0; JZ if Z = 1; JNZ if Z = 0; J always.
    - Taken: pc_out <= target and jump_taken = 1.
    - Not taken: pc_out <= pc_out + 1, skipping the address byte; jump_taken = 0.
    - Next state is FETCH.
- flags is sampled only in the ADDR cycle, using the value present on that clock edge.
- flags_load and jump_taken are combinational decodes of state, ir_out, instr and flags, gated by !hold.
- PC arithmetic is modulo 2^12: an increment from 0xFFF gives 0x000. This applies in both FETCH and not-taken ADDR.
- A jump whose second byte sits at 0xFFF reads its address byte from 0xFFF and wraps to 0x000 when not taken.
- Reset values: pc_out = 0x000, ir_out = 0x00, phase = FETCH, flags_load = 0, jump_taken = 0.
- Reset asserted mid-instruction (any state) aborts it immediately. No flags_load or jump_taken is produced, and execution restarts at FETCH with PC 0x000 after release.
- hold and reset together: reset dominates.
- hold deasserting resumes in the frozen state with no lost or repeated strobes.

## Timing
- Single-byte instruction: 2 cycles (FETCH, EXEC).
- Jump: 2 cycles (FETCH, ADDR), taken or not.
- ROM read is combinational. pc_out changes only on clock edges, so instr must settle within one cycle.
- flags_load is high for exactly one cycle (EXEC). The Flags register captures C/Z at the end of that cycle. The new flags are visible to a jump in the immediately following instruction, because that jump's ADDR cycle comes at least one cycle later.
- jump_taken is high for exactly one cycle (ADDR). pc_out shows the target on the following cycle.
- Reset release: the first FETCH occurs on the first rising edge with reset = 1, reading address 0x000.

## Test plan
- Reset: hold reset = 0 for 3 cycles, then release. Required: pc_out = 0x000, phase = 0 and ir_out = 0x00 during reset; the first fetch latches ROM[0].
- Straight-line ALU ops: ROM[0..2] = 0x12, 0x34, 0xD0. Required: pc_out sequence 0, 1, 1, 2, 2, 3; flags_load pulses in the EXEC of 0x12 and 0x34 only.
- Conditional jumps: ROM[0..1] = 0xA5, 0x67 (JZ 0x567).
  - flags = 2'b01: jump_taken = 1, then pc_out = 0x567.
  - flags = 2'b00: jump_taken = 0, then pc_out = 0x002.
  - Repeat for JC/JNC/JNZ using flags values 10/00/00/01.
- Wrap: force execution to PC 0xFFF with a NOP. Required: the next pc_out = 0x000. A JNZ whose opcode byte is at 0xFFE, not taken, leads to pc_out 0x000.
- Hold: assert hold during an EXEC cycle for 4 cycles. Required: pc_out, ir_out and phase are frozen and flags_load = 0. After release, exactly one flags_load pulse occurs.
- Reset mid-jump: assert reset during ADDR with a taken condition. Required: jump_taken = 0 immediately, pc_out = 0x000, and execution restarts at ROM[0].
